// File: rtl/cache_pkg.sv
// Shared widths, types and address helpers for the L1 cache controller.
//   MM_BLOCK_COUNT / L1_BLOCK_COUNT set the address split {tag, index}.
//   l1_state_t : controller FSM states.
//   cpu_req_t  : request fields latched when a CPU request is accepted.
package cache_pkg;

    localparam int unsigned MM_BLOCK_COUNT = 1024;
    localparam int unsigned L1_BLOCK_COUNT = 64;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned CNT_WIDTH      = 16;

    localparam int unsigned ADDR_BITS  = $clog2(MM_BLOCK_COUNT);
    localparam int unsigned INDEX_BITS = $clog2(L1_BLOCK_COUNT);
    localparam int unsigned TAG_BITS   = ADDR_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } l1_state_t;

    typedef struct packed {
        logic                  rw;
        logic [ADDR_BITS-1:0]  addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cpu_req_t;

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] addr);
        return addr[INDEX_BITS-1:0];
    endfunction

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] addr);
        return addr[ADDR_BITS-1:INDEX_BITS];
    endfunction

endpackage

// File: rtl/l1_line_store.sv
// L1 line storage: data, tag, valid and dirty per block, all cleared by reset.
//   clk, reset           : clock, asynchronous active-high clear of every field
//   rd_index             : combinational read port index
//   rd_data/tag/valid/dirty : contents of the addressed line
//   wr_index             : write port index
//   wr_*_en / wr_*       : per-field write enable and value, applied on the rising edge
module l1_line_store
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_data_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_tag_en,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic                  wr_valid_en,
    input  logic                  wr_valid,
    input  logic                  wr_dirty_en,
    input  logic                  wr_dirty
);

    logic [DATA_WIDTH-1:0]     data_q [L1_BLOCK_COUNT];
    logic [TAG_BITS-1:0]       tag_q  [L1_BLOCK_COUNT];
    logic [L1_BLOCK_COUNT-1:0] valid_q;
    logic [L1_BLOCK_COUNT-1:0] dirty_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < L1_BLOCK_COUNT; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (wr_data_en) begin
                data_q[wr_index] <= wr_data;
            end
            if (wr_tag_en) begin
                tag_q[wr_index] <= wr_tag;
            end
            if (wr_valid_en) begin
                valid_q[wr_index] <= wr_valid;
            end
            if (wr_dirty_en) begin
                dirty_q[wr_index] <= wr_dirty;
            end
        end
    end

    always_comb begin
        rd_data  = data_q[rd_index];
        rd_tag   = tag_q[rd_index];
        rd_valid = valid_q[rd_index];
        rd_dirty = dirty_q[rd_index];
    end

endmodule

// File: rtl/l1_cache_controller.sv
// Direct-mapped, write-back, write-allocate L1 controller, one word per block.
//   clk, reset      : clock; asynchronous active-high reset (aborts any transaction)
//   cpu_req_*       : CPU request, accepted only while cpu_req_ready (IDLE)
//   cpu_resp_*      : one-cycle completion pulse; rdata holds until the next response
//   mem_req_*       : memory transaction, Moore outputs of WRITEBACK / ALLOCATE
//   mem_ack/rdata   : transaction done; refill data valid with the ack
//   hit_count/miss_count : saturating per-request hit and miss counters
module l1_cache_controller #(
    parameter int unsigned CNT_WIDTH = cache_pkg::CNT_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cpu_req_valid,
    output logic                             cpu_req_ready,
    input  logic                             cpu_req_rw,
    input  logic [cache_pkg::ADDR_BITS-1:0]  cpu_req_addr,
    input  logic [cache_pkg::DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                             cpu_resp_valid,
    output logic [cache_pkg::DATA_WIDTH-1:0] cpu_resp_rdata,
    output logic                             mem_req_valid,
    output logic                             mem_req_rw,
    output logic [cache_pkg::ADDR_BITS-1:0]  mem_req_addr,
    output logic [cache_pkg::DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                             mem_ack,
    input  logic [cache_pkg::DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]             hit_count,
    output logic [CNT_WIDTH-1:0]             miss_count
);

    import cache_pkg::*;

    l1_state_t             state_q, state_d;
    cpu_req_t              req_q, req_d;
    // Set once a refill lands so the follow-up COMPARE is not counted again.
    logic                  refill_q, refill_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [CNT_WIDTH-1:0]  hit_q, hit_d;
    logic [CNT_WIDTH-1:0]  miss_q, miss_d;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [DATA_WIDTH-1:0] line_data;
    logic [TAG_BITS-1:0]   line_tag;
    logic                  line_valid;
    logic                  line_dirty;
    logic                  hit;

    logic                  wr_data_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_tag_en;
    logic                  wr_valid_en;
    logic                  wr_dirty_en;
    logic                  wr_dirty;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign req_index = addr_index(req_q.addr);
    assign req_tag   = addr_tag(req_q.addr);
    assign hit       = line_valid && (line_tag == req_tag);

    l1_line_store u_line_store (
        .clk         (clk),
        .reset       (reset),
        .rd_index    (req_index),
        .rd_data     (line_data),
        .rd_tag      (line_tag),
        .rd_valid    (line_valid),
        .rd_dirty    (line_dirty),
        .wr_index    (req_index),
        .wr_data_en  (wr_data_en),
        .wr_data     (wr_data),
        .wr_tag_en   (wr_tag_en),
        .wr_tag      (req_tag),
        .wr_valid_en (wr_valid_en),
        .wr_valid    (1'b1),
        .wr_dirty_en (wr_dirty_en),
        .wr_dirty    (wr_dirty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            refill_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            refill_q     <= refill_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // Next state, line-store writes and response/counter updates.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        refill_d     = refill_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        wr_data_en   = 1'b0;
        wr_data      = req_q.wdata;
        wr_tag_en    = 1'b0;
        wr_valid_en  = 1'b0;
        wr_dirty_en  = 1'b0;
        wr_dirty     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_valid) begin
                    req_d.rw    = cpu_req_rw;
                    req_d.addr  = cpu_req_addr;
                    req_d.wdata = cpu_req_wdata;
                    refill_d    = 1'b0;
                    state_d     = COMPARE;
                end
            end
            COMPARE: begin
                if (!refill_q) begin
                    if (hit) begin
                        hit_d = sat_inc(hit_q);
                    end else begin
                        miss_d = sat_inc(miss_q);
                    end
                end
                if (hit) begin
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                    if (req_q.rw) begin
                        wr_data_en   = 1'b1;
                        wr_data      = req_q.wdata;
                        wr_dirty_en  = 1'b1;
                        wr_dirty     = 1'b1;
                        resp_rdata_d = req_q.wdata;
                    end else begin
                        resp_rdata_d = line_data;
                    end
                end else if (line_valid && line_dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (mem_ack) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_ack) begin
                    wr_data_en  = 1'b1;
                    wr_data     = mem_rdata;
                    wr_tag_en   = 1'b1;
                    wr_valid_en = 1'b1;
                    wr_dirty_en = 1'b1;
                    wr_dirty    = 1'b0;
                    refill_d    = 1'b1;
                    state_d     = COMPARE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port is purely a function of state; the line being written back is not
    // modified while in WRITEBACK, so its tag/data are stable until the ack.
    always_comb begin
        cpu_req_ready = (state_q == IDLE);
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (state_q)
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {line_tag, req_index};
                mem_req_wdata = line_data;
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = req_q.addr;
            end
            default: begin
                mem_req_valid = 1'b0;
            end
        endcase
    end

    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = resp_rdata_q;
    assign hit_count      = hit_q;
    assign miss_count     = miss_q;

endmodule

// File: tb/tb_l1_cache_controller.sv
// Self-checking bench for l1_cache_controller: directed table, reset abort,
// randomized traffic against a flat-memory reference model, counter saturation.
module tb_l1_cache_controller;

    localparam int CNT_W = 10;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int NMEM  = 1024;
    localparam int NL1   = 64;

    logic              clk;
    logic              reset;
    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_req_rw;
    logic [9:0]        cpu_req_addr;
    logic [31:0]       cpu_req_wdata;
    logic              cpu_resp_valid;
    logic [31:0]       cpu_resp_rdata;
    logic              mem_req_valid;
    logic              mem_req_rw;
    logic [9:0]        mem_req_addr;
    logic [31:0]       mem_req_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    l1_cache_controller #(.CNT_WIDTH(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_rw     (cpu_req_rw),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Main memory and transaction log
    typedef struct packed {
        logic        rw;
        logic [9:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic [31:0] mem [NMEM];
    txn_t        txq[$];
    bit          mem_hold;
    bit          noise;
    int          mem_wait;

    function automatic logic [31:0] init_word(input int a);
        if (a == 0) return 32'hDEADBEEF;
        return {6'd0, 10'(a), 16'hC0DE};
    endfunction

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_wait  = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req_valid && !reset && !mem_hold) begin
                if (mem_wait == 0) begin
                    mem_ack = 1'b1;
                    if (mem_req_rw) begin
                        mem[mem_req_addr] = mem_req_wdata;
                        mem_rdata = $urandom;
                        txq.push_back(txn_t'{rw: 1'b1, addr: mem_req_addr, data: mem_req_wdata});
                    end else begin
                        mem_rdata = mem[mem_req_addr];
                        txq.push_back(txn_t'{rw: 1'b0, addr: mem_req_addr, data: mem_rdata});
                    end
                    mem_wait = $urandom_range(0, 3);
                end else begin
                    mem_wait = mem_wait - 1;
                end
            end else if (!mem_req_valid && noise) begin
                // Acks with no transaction open must be ignored.
                mem_ack   = 1'($urandom & 1);
                mem_rdata = $urandom;
            end
        end
    end

    // Reference model: architectural value of every address plus which address
    // each direct-mapped slot currently holds.
    logic [31:0] arch    [NMEM];
    bit          m_valid [NL1];
    bit          m_dirty [NL1];
    logic [9:0]  m_addr  [NL1];
    int          m_hits;
    int          m_misses;

    task automatic model_reset();
        for (int i = 0; i < NMEM; i++) arch[i] = mem[i];
        for (int i = 0; i < NL1; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_addr[i]  = '0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_step(input logic rw, input logic [9:0] addr, input logic [31:0] wd,
                              output logic [31:0] e_rd, output bit e_hit, output bit e_wb,
                              output logic [9:0] e_wb_addr, output logic [31:0] e_wb_data);
        int slot;
        slot      = int'(addr) % NL1;
        e_hit     = m_valid[slot] && (m_addr[slot] == addr);
        e_wb      = 1'b0;
        e_wb_addr = '0;
        e_wb_data = '0;
        if (e_hit) begin
            m_hits = (m_hits < CMAX) ? m_hits + 1 : CMAX;
        end else begin
            m_misses = (m_misses < CMAX) ? m_misses + 1 : CMAX;
            if (m_valid[slot] && m_dirty[slot]) begin
                e_wb      = 1'b1;
                e_wb_addr = m_addr[slot];
                e_wb_data = arch[m_addr[slot]];
            end
            m_valid[slot] = 1'b1;
            m_dirty[slot] = 1'b0;
            m_addr[slot]  = addr;
        end
        if (rw) begin
            arch[addr]    = wd;
            m_dirty[slot] = 1'b1;
            e_rd          = wd;
        end else begin
            e_rd = arch[addr];
        end
    endtask

    // Issue one request from a negedge with the DUT idle; returns at the negedge
    // of the response cycle.
    task automatic run_op(input logic rw, input logic [9:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output int mv,
                          output bit timeout);
        cpu_req_valid = 1'b1;
        cpu_req_rw    = rw;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        @(posedge clk);
        rd      = '0;
        lat     = 0;
        mv      = 0;
        timeout = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            cpu_req_valid = 1'b0;
            if (mem_req_valid) mv++;
            if (cpu_resp_valid) begin
                lat     = c;
                rd      = cpu_resp_rdata;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic rw, input logic [9:0] addr,
                            input logic [31:0] wd, input logic [31:0] e_rd, input bit e_hit,
                            input bit e_wb, input logic [9:0] e_wb_addr,
                            input logic [31:0] e_wb_data, input int e_hits, input int e_misses);
        logic [31:0] rd;
        int          lat;
        int          mv;
        bit          to;
        int          n_exp;
        check({name, " ready"}, 32'(cpu_req_ready), 32'd1);
        txq.delete();
        run_op(rw, addr, wd, rd, lat, mv, to);
        check({name, " timeout"}, 32'(to), 32'd0);
        check({name, " rdata"}, rd, e_rd);
        if (e_hit) begin
            check({name, " hit latency"}, 32'(lat), 32'd2);
            check({name, " hit mem_req_valid cycles"}, 32'(mv), 32'd0);
        end else begin
            check({name, " miss latency>=4"}, 32'(lat >= 4), 32'd1);
        end
        n_exp = e_hit ? 0 : (e_wb ? 2 : 1);
        check({name, " mem txn count"}, 32'(txq.size()), 32'(n_exp));
        if (txq.size() == n_exp && n_exp > 0) begin
            if (e_wb) begin
                check({name, " wb rw"}, 32'(txq[0].rw), 32'd1);
                check({name, " wb addr"}, 32'(txq[0].addr), 32'(e_wb_addr));
                check({name, " wb data"}, txq[0].data, e_wb_data);
            end
            check({name, " refill rw"}, 32'(txq[n_exp-1].rw), 32'd0);
            check({name, " refill addr"}, 32'(txq[n_exp-1].addr), 32'(addr));
        end
        check({name, " hit_count"}, 32'(hit_count), 32'(e_hits));
        check({name, " miss_count"}, 32'(miss_count), 32'(e_misses));
    endtask

    typedef struct {
        logic        rw;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_hit;
        bit          exp_wb;
        logic [9:0]  exp_wb_addr;
        logic [31:0] exp_wb_data;
        int          exp_hits;
        int          exp_misses;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e_rd;
        bit          e_hit;
        bit          e_wb;
        logic [9:0]  e_wb_addr;
        logic [31:0] e_wb_data;
        bit          found;
        int          n;
        int          acc;
        int          resp;
        int          bad;
        int          dbl;
        bit          prev;
        logic [31:0] exp;

        reset         = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        mem_hold      = 1'b0;
        noise         = 1'b0;
        for (int i = 0; i < NMEM; i++) mem[i] = init_word(i);
        model_reset();

        vecs[0] = '{1'b0, 10'h000, 32'h0,    32'hDEADBEEF, 1'b0, 1'b0, 10'h000, 32'h0,    0, 1};
        vecs[1] = '{1'b0, 10'h000, 32'h0,    32'hDEADBEEF, 1'b1, 1'b0, 10'h000, 32'h0,    1, 1};
        vecs[2] = '{1'b1, 10'h005, 32'h1234, 32'h1234,     1'b0, 1'b0, 10'h000, 32'h0,    1, 2};
        vecs[3] = '{1'b0, 10'h045, 32'h0,    32'h0045C0DE, 1'b0, 1'b1, 10'h005, 32'h1234, 1, 3};
        vecs[4] = '{1'b0, 10'h005, 32'h0,    32'h1234,     1'b0, 1'b0, 10'h000, 32'h0,    1, 4};
        vecs[5] = '{1'b1, 10'h045, 32'hCAFE, 32'hCAFE,     1'b0, 1'b0, 10'h000, 32'h0,    1, 5};
        vecs[6] = '{1'b0, 10'h045, 32'h0,    32'hCAFE,     1'b1, 1'b0, 10'h000, 32'h0,    2, 5};
        vecs[7] = '{1'b1, 10'h045, 32'hBEEF, 32'hBEEF,     1'b1, 1'b0, 10'h000, 32'h0,    3, 5};
        vecs[8] = '{1'b0, 10'h085, 32'h0,    32'h0085C0DE, 1'b0, 1'b1, 10'h045, 32'hBEEF, 3, 6};

        // Reset state
        @(negedge clk);
        check("reset cpu_req_ready", 32'(cpu_req_ready), 32'd1);
        check("reset cpu_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("reset cpu_resp_rdata", cpu_resp_rdata, 32'd0);
        check("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("reset mem_req_rw", 32'(mem_req_rw), 32'd0);
        check("reset mem_req_addr", 32'(mem_req_addr), 32'd0);
        check("reset mem_req_wdata", mem_req_wdata, 32'd0);
        check("reset hit_count", 32'(hit_count), 32'd0);
        check("reset miss_count", 32'(miss_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            model_step(vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                       e_rd, e_hit, e_wb, e_wb_addr, e_wb_data);
            check_op($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                     vecs[i].exp_rdata, vecs[i].exp_hit, vecs[i].exp_wb, vecs[i].exp_wb_addr,
                     vecs[i].exp_wb_data, vecs[i].exp_hits, vecs[i].exp_misses);
        end

        // Reset while a refill is outstanding
        mem_hold      = 1'b1;
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = 10'h010;
        cpu_req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mem_req_valid && !mem_req_rw) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort reached allocate", 32'(found), 32'd1);
        check("abort allocate addr", 32'(mem_req_addr), 32'h010);
        reset = 1'b1;
        #1;
        check("abort mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("abort cpu_req_ready", 32'(cpu_req_ready), 32'd1);
        check("abort hit_count", 32'(hit_count), 32'd0);
        check("abort miss_count", 32'(miss_count), 32'd0);
        check("abort cpu_resp_rdata", cpu_resp_rdata, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        mem_hold = 1'b0;
        model_reset();
        @(negedge clk);
        model_step(1'b0, 10'h010, 32'h0, e_rd, e_hit, e_wb, e_wb_addr, e_wb_data);
        check_op("post-abort read", 1'b0, 10'h010, 32'h0, e_rd, e_hit, e_wb,
                 e_wb_addr, e_wb_data, m_hits, m_misses);
        check("post-abort missed", 32'(m_misses), 32'd1);

        // Randomized traffic over a few conflicting slots, with stray acks
        noise = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic        rw;
            logic [9:0]  addr;
            logic [31:0] wd;
            rw   = 1'($urandom & 1);
            addr = 10'($urandom_range(0, 3) * NL1 + $urandom_range(0, 7));
            wd   = $urandom;
            model_step(rw, addr, wd, e_rd, e_hit, e_wb, e_wb_addr, e_wb_data);
            check_op($sformatf("rnd%0d", i), rw, addr, wd, e_rd, e_hit, e_wb,
                     e_wb_addr, e_wb_data, m_hits, m_misses);
        end

        // Back-to-back hits up to and past hit counter saturation
        model_step(1'b0, 10'h3FF, 32'h0, e_rd, e_hit, e_wb, e_wb_addr, e_wb_data);
        check_op("sat prime", 1'b0, 10'h3FF, 32'h0, e_rd, e_hit, e_wb,
                 e_wb_addr, e_wb_data, m_hits, m_misses);
        n    = CMAX - m_hits + 4;
        exp  = arch[10'h3FF];
        acc  = 0;
        resp = 0;
        bad  = 0;
        dbl  = 0;
        prev = 1'b0;
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = 10'h3FF;
        for (int c = 0; c < 4 * n + 20; c++) begin
            if (acc >= n && resp >= acc) break;
            if (cpu_req_valid && cpu_req_ready) acc++;
            @(posedge clk);
            @(negedge clk);
            if (acc >= n) cpu_req_valid = 1'b0;
            if (cpu_resp_valid) begin
                resp++;
                if (cpu_resp_rdata !== exp) bad++;
                if (prev) dbl++;
            end
            prev = cpu_resp_valid;
        end
        cpu_req_valid = 1'b0;
        check("b2b responses", 32'(resp), 32'(n));
        check("b2b bad rdata", 32'(bad), 32'd0);
        check("b2b stretched pulses", 32'(dbl), 32'd0);
        m_hits = (m_hits + n > CMAX) ? CMAX : m_hits + n;
        check("sat hit_count", 32'(hit_count), 32'(m_hits));
        check("sat miss_count", 32'(miss_count), 32'(m_misses));
        for (int i = 0; i < 2; i++) begin
            model_step(1'b0, 10'h3FF, 32'h0, e_rd, e_hit, e_wb, e_wb_addr, e_wb_data);
            check_op($sformatf("sat hold%0d", i), 1'b0, 10'h3FF, 32'h0, e_rd, e_hit, e_wb,
                     e_wb_addr, e_wb_data, m_hits, m_misses);
        end
        check("sat value", 32'(hit_count), 32'(CMAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
